// File: rtl/vga_fb_pkg.sv
// Shared VGA 640x480@60 timing constants, sync polarity and pixel-clock divide ratio
// for the double-buffered framebuffer.
`timescale 1ns/1ps
package vga_fb_pkg;
    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic SYNC_POL = 1'b0;

    // 50 MHz system clock / 2 gives the 25 MHz pixel rate.
    localparam int PE_DIV = 2;
    localparam int PH_W   = (PE_DIV > 1) ? $clog2(PE_DIV) : 1;
    localparam int CNT_W  = 10;
endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, H/V counters, raw sync/visible flags and the vblank-start strobe.
// All outputs are combinational decodes of the counter registers.
`timescale 1ns/1ps
module vga_timing_gen
    import vga_fb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic             pe,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             hs,
    output logic             vs,
    output logic             vis,
    output logic             vbl_start
);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VIS + V_FP + V_SYNC);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PE_DIV - 1);

    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    assign pe = (phase == PH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            phase <= pe ? '0 : phase + 1'b1;
            if (pe) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    assign h         = h_cnt;
    assign v         = v_cnt;
    assign hs        = (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    assign vs        = (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
    assign vis       = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    // Qualified with pe: the counters step to (0, V_VIS) on this very edge.
    assign vbl_start = pe && (h_cnt == H_LAST) && (v_cnt == V_VIS_C - 1'b1);
endmodule

// File: rtl/vga_fb_dbuf.sv
// Double-buffered, pixel-replicated VGA framebuffer: host writes/reads the back page,
// display scans the front page, pages swap at vblank start. Macro VGA_FB_VBLANK_IRQ_EN adds VBLANK_INT.
`timescale 1ns/1ps
module vga_fb_dbuf
    import vga_fb_pkg::*;
#(
    parameter  int SCALE_LOG2 = 3,
    parameter  int R_W        = 3,
    parameter  int G_W        = 3,
    parameter  int B_W        = 2,
    localparam int COLOR_W    = R_W + G_W + B_W,
    localparam int COL_W      = $clog2(H_VIS >> SCALE_LOG2),
    localparam int ROW_W      = $clog2(V_VIS >> SCALE_LOG2),
    localparam int ADDR_W     = ROW_W + COL_W
)(
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [ADDR_W-1:0]  WA,
    input  logic [COLOR_W-1:0] WD,
    input  logic               WE,
    output logic [COLOR_W-1:0] RD,
    input  logic               FLIP_REQ,
    output logic               FLIP_DONE,
    output logic               PAGE,
    output logic               VBLANK_INT,
    output logic [R_W-1:0]     ROUT,
    output logic [G_W-1:0]     GOUT,
    output logic [B_W-1:0]     BOUT,
    output logic               HS,
    output logic               VS
);
    logic             pe, hs_raw, vs_raw, vis_raw, vbl_start;
    logic [CNT_W-1:0] h, v;

    vga_timing_gen u_tg (
        .clk       (CLK),
        .rst_n     (RST_N),
        .pe        (pe),
        .h         (h),
        .v         (v),
        .hs        (hs_raw),
        .vs        (vs_raw),
        .vis       (vis_raw),
        .vbl_start (vbl_start)
    );

    // Page is the MSB of the address; the two pages share one array.
    logic [COLOR_W-1:0] mem [2**(ADDR_W+1)];
    logic [ADDR_W:0]    disp_addr;
    logic               unused_hv;

    assign disp_addr = {PAGE, v[ROW_W+SCALE_LOG2-1:SCALE_LOG2], h[COL_W+SCALE_LOG2-1:SCALE_LOG2]};
    assign unused_hv = ^{h, v};

    always_ff @(posedge CLK) begin
        if (WE)
            mem[{~PAGE, WA}] <= WD;
        RD <= mem[{~PAGE, WA}];
    end

    logic [COLOR_W-1:0] pix_q;
    logic               vis_q, hs_q, vs_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pix_q <= '0;
            vis_q <= 1'b0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            ROUT  <= '0;
            GOUT  <= '0;
            BOUT  <= '0;
            HS    <= ~SYNC_POL;
            VS    <= ~SYNC_POL;
        end else if (pe) begin
            pix_q              <= mem[disp_addr];
            vis_q              <= vis_raw;
            hs_q               <= hs_raw;
            vs_q               <= vs_raw;
            {ROUT, GOUT, BOUT} <= vis_q ? pix_q : '0;
            HS                 <= hs_q;
            VS                 <= vs_q;
        end
    end

    // A request landing on the swap edge itself sees pending=0, so it waits a frame.
    logic pending;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PAGE      <= 1'b0;
            pending   <= 1'b0;
            FLIP_DONE <= 1'b0;
        end else begin
            FLIP_DONE <= 1'b0;
            if (vbl_start && pending) begin
                PAGE      <= ~PAGE;
                pending   <= 1'b0;
                FLIP_DONE <= 1'b1;
            end else if (FLIP_REQ) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef VGA_FB_VBLANK_IRQ_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            VBLANK_INT <= 1'b0;
        else
            VBLANK_INT <= vbl_start;
    end
`else
    assign VBLANK_INT = 1'b0;
`endif
endmodule

// File: tb/tb_vga_fb_dbuf.sv
// Directed bench for vga_fb_dbuf; frame positions are reached by depositing the
// timing counters so each scenario needs only a few thousand clocks.
`timescale 1ns/1ps
module tb_vga_fb_dbuf;
    logic        CLK = 1'b0, RST_N = 1'b0;
    logic [12:0] WA = '0;
    logic [7:0]  WD = '0;
    logic        WE = 1'b0, FLIP_REQ = 1'b0;
    logic [7:0]  RD;
    logic        FLIP_DONE, PAGE, VBLANK_INT, HS, VS;
    logic [2:0]  ROUT, GOUT;
    logic [1:0]  BOUT;

    int n_tests = 0, n_fail = 0, flip_cnt = 0;
    logic [9:0] jh, jv;

    vga_fb_dbuf dut (
        .CLK(CLK), .RST_N(RST_N), .WA(WA), .WD(WD), .WE(WE), .RD(RD),
        .FLIP_REQ(FLIP_REQ), .FLIP_DONE(FLIP_DONE), .PAGE(PAGE), .VBLANK_INT(VBLANK_INT),
        .ROUT(ROUT), .GOUT(GOUT), .BOUT(BOUT), .HS(HS), .VS(VS)
    );

    always #10 CLK = ~CLK;
    always @(negedge CLK) if (FLIP_DONE === 1'b1) flip_cnt++;

    // Place the counters at (h, v) with PE phase 0, exactly as after reset release:
    // the first following edge only toggles the phase, the second one advances.
    task automatic jump(input logic [9:0] h, input logic [9:0] v);
        @(negedge CLK);
        jh = h; jv = v;
        force dut.u_tg.h_cnt = jh;
        force dut.u_tg.v_cnt = jv;
        force dut.u_tg.phase = 1'b0;
        #1;
        release dut.u_tg.h_cnt;
        release dut.u_tg.v_cnt;
        release dut.u_tg.phase;
    endtask

    task automatic after_edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        @(negedge CLK); WA = a; WD = d; WE = 1'b1;
        @(negedge CLK); WE = 1'b0;
    endtask

    task automatic pulse_req();
        @(negedge CLK); FLIP_REQ = 1'b1;
        @(negedge CLK); FLIP_REQ = 1'b0;
    endtask

    task automatic test_reset();
        #25;
        n_tests++; if (HS !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %b want 1", HS); end
        n_tests++; if (VS !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %b want 1", VS); end
        n_tests++; if (PAGE !== 1'b0) begin n_fail++; $display("FAIL reset_page: got %b want 0", PAGE); end
        n_tests++; if (FLIP_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_flip_done: got %b want 0", FLIP_DONE); end
        n_tests++; if (VBLANK_INT !== 1'b0) begin n_fail++; $display("FAIL reset_vblank: got %b want 0", VBLANK_INT); end
        n_tests++; if ({ROUT, GOUT, BOUT} !== 8'h00) begin n_fail++; $display("FAIL reset_colour: got %h want 00", {ROUT, GOUT, BOUT}); end
        @(negedge CLK); RST_N = 1'b1;
    endtask

    // HS reflects counter h=k after edge 2k+4 (two PE of pipeline).
    task automatic test_hsync();
        int lows = 0;
        for (int e = 1; e <= 1600; e++) begin
            after_edges(1);
            if (HS === 1'b0) lows++;
            if (e == 1315) begin n_tests++; if (HS !== 1'b1) begin n_fail++; $display("FAIL hs_before_sync: got %b want 1", HS); end end
            if (e == 1316) begin n_tests++; if (HS !== 1'b0) begin n_fail++; $display("FAIL hs_sync_start: got %b want 0", HS); end end
            if (e == 1507) begin n_tests++; if (HS !== 1'b0) begin n_fail++; $display("FAIL hs_sync_last: got %b want 0", HS); end end
            if (e == 1508) begin n_tests++; if (HS !== 1'b1) begin n_fail++; $display("FAIL hs_sync_end: got %b want 1", HS); end end
        end
        n_tests++; if (lows != 192) begin n_fail++; $display("FAIL hs_low_clks: got %0d want 192", lows); end
    endtask

    task automatic test_vsync();
        int lows = 0;
        jump(10'd0, 10'd489);
        for (int e = 1; e <= 6400; e++) begin
            after_edges(1);
            if (VS === 1'b0) lows++;
            if (e == 1603) begin n_tests++; if (VS !== 1'b1) begin n_fail++; $display("FAIL vs_line489: got %b want 1", VS); end end
            if (e == 1604) begin n_tests++; if (VS !== 1'b0) begin n_fail++; $display("FAIL vs_line490: got %b want 0", VS); end end
            if (e == 4803) begin n_tests++; if (VS !== 1'b0) begin n_fail++; $display("FAIL vs_line491: got %b want 0", VS); end end
            if (e == 4804) begin n_tests++; if (VS !== 1'b1) begin n_fail++; $display("FAIL vs_line492: got %b want 1", VS); end end
        end
        n_tests++; if (lows != 3200) begin n_fail++; $display("FAIL vs_low_clks: got %0d want 3200", lows); end
    endtask

    task automatic test_flip_pixel();
        int fc0;
        logic vb_exp;
`ifdef VGA_FB_VBLANK_IRQ_EN
        vb_exp = 1'b1;
`else
        vb_exp = 1'b0;
`endif
        wr(13'h0000, 8'hE0);
        wr(13'h004F, 8'hFF);   // row 0, col 79
        wr(13'h1E00, 8'hFF);   // row 60, col 0 (blank region alias)
        pulse_req();
        fc0 = flip_cnt;
        jump(10'd799, 10'd479);
        after_edges(1);
        n_tests++; if (PAGE !== 1'b0) begin n_fail++; $display("FAIL flip_page_before: got %b want 0", PAGE); end
        after_edges(1);
        n_tests++; if (FLIP_DONE !== 1'b1) begin n_fail++; $display("FAIL flip_done_pulse: got %b want 1", FLIP_DONE); end
        n_tests++; if (PAGE !== 1'b1) begin n_fail++; $display("FAIL flip_page_after: got %b want 1", PAGE); end
        n_tests++; if (VBLANK_INT !== vb_exp) begin n_fail++; $display("FAIL vblank_int: got %b want %b", VBLANK_INT, vb_exp); end
        after_edges(1);
        n_tests++; if (FLIP_DONE !== 1'b0) begin n_fail++; $display("FAIL flip_done_width: got %b want 0", FLIP_DONE); end
        n_tests++; if (flip_cnt != fc0 + 1) begin n_fail++; $display("FAIL flip_count: got %0d want %0d", flip_cnt, fc0 + 1); end

        jump(10'd0, 10'd0);
        after_edges(2);
        for (int k = 0; k < 8; k++) begin
            after_edges(2);
            n_tests++; if ({ROUT, GOUT, BOUT} !== 8'hE0) begin n_fail++; $display("FAIL pix_row0_h%0d: got %h want e0", k, {ROUT, GOUT, BOUT}); end
        end
        jump(10'd0, 10'd7);
        after_edges(4);
        n_tests++; if ({ROUT, GOUT, BOUT} !== 8'hE0) begin n_fail++; $display("FAIL pix_row7: got %h want e0", {ROUT, GOUT, BOUT}); end

        jump(10'd632, 10'd0);
        after_edges(2);
        for (int k = 0; k <= 8; k++) begin
            after_edges(2);
            n_tests++;
            if ({ROUT, GOUT, BOUT} !== ((k < 8) ? 8'hFF : 8'h00)) begin
                n_fail++; $display("FAIL pix_h%0d: got %h want %h", 632 + k, {ROUT, GOUT, BOUT}, (k < 8) ? 8'hFF : 8'h00);
            end
        end
        jump(10'd0, 10'd480);
        after_edges(4);
        n_tests++; if ({ROUT, GOUT, BOUT} !== 8'h00) begin n_fail++; $display("FAIL pix_vblank: got %h want 00", {ROUT, GOUT, BOUT}); end

        jump(10'd799, 10'd524);
        after_edges(6);
        n_tests++; if ({ROUT, GOUT, BOUT} !== 8'hE0) begin n_fail++; $display("FAIL v_wrap: got %h want e0", {ROUT, GOUT, BOUT}); end
        jump(10'd799, 10'd0);
        after_edges(6);
        n_tests++; if ({ROUT, GOUT, BOUT} !== 8'hE0) begin n_fail++; $display("FAIL h_wrap: got %h want e0", {ROUT, GOUT, BOUT}); end
    endtask

    task automatic test_absorb();
        int fc0 = flip_cnt;
        for (int i = 0; i < 3; i++) begin
            pulse_req();
            after_edges(5);
        end
        jump(10'd799, 10'd479);
        after_edges(3);
        n_tests++; if (PAGE !== 1'b0) begin n_fail++; $display("FAIL absorb_page1: got %b want 0", PAGE); end
        jump(10'd799, 10'd479);
        after_edges(3);
        n_tests++; if (PAGE !== 1'b0) begin n_fail++; $display("FAIL absorb_page2: got %b want 0", PAGE); end
        n_tests++; if (flip_cnt != fc0 + 1) begin n_fail++; $display("FAIL absorb_count: got %0d want %0d", flip_cnt, fc0 + 1); end
    endtask

    task automatic test_deferred();
        int fc0 = flip_cnt;
        jump(10'd799, 10'd479);
        after_edges(1);
        FLIP_REQ = 1'b1;
        after_edges(1);
        FLIP_REQ = 1'b0;
        n_tests++; if (PAGE !== 1'b0) begin n_fail++; $display("FAIL defer_page: got %b want 0", PAGE); end
        n_tests++; if (FLIP_DONE !== 1'b0) begin n_fail++; $display("FAIL defer_done: got %b want 0", FLIP_DONE); end
        after_edges(2);
        n_tests++; if (flip_cnt != fc0) begin n_fail++; $display("FAIL defer_count: got %0d want %0d", flip_cnt, fc0); end
        jump(10'd799, 10'd479);
        after_edges(2);
        n_tests++; if (FLIP_DONE !== 1'b1) begin n_fail++; $display("FAIL defer_next_done: got %b want 1", FLIP_DONE); end
        n_tests++; if (PAGE !== 1'b1) begin n_fail++; $display("FAIL defer_next_page: got %b want 1", PAGE); end
    endtask

    // Entered with PAGE=1, so the host side sees page 0.
    task automatic test_rdwr();
        @(negedge CLK); WA = 13'h1234; WD = 8'h5A; WE = 1'b1;
        @(negedge CLK); WE = 1'b0;
        @(negedge CLK);
        n_tests++; if (RD !== 8'h5A) begin n_fail++; $display("FAIL rd_after_wr: got %h want 5a", RD); end
        WD = 8'hA5; WE = 1'b1;
        @(negedge CLK); WE = 1'b0;
        n_tests++; if (RD !== 8'h5A) begin n_fail++; $display("FAIL rd_read_first: got %h want 5a", RD); end
        @(negedge CLK);
        n_tests++; if (RD !== 8'hA5) begin n_fail++; $display("FAIL rd_new: got %h want a5", RD); end

        pulse_req();
        jump(10'd799, 10'd479);
        after_edges(1);
        WA = 13'h0ABC; WD = 8'h77; WE = 1'b1;   // write on the swap clock
        after_edges(1);
        WE = 1'b0;
        n_tests++; if (PAGE !== 1'b0) begin n_fail++; $display("FAIL rdwr_flip1_page: got %b want 0", PAGE); end
        wr(13'h1234, 8'h3C);
        @(negedge CLK);
        n_tests++; if (RD !== 8'h3C) begin n_fail++; $display("FAIL rd_page1: got %h want 3c", RD); end

        pulse_req();
        jump(10'd799, 10'd479);
        after_edges(3);
        n_tests++; if (PAGE !== 1'b1) begin n_fail++; $display("FAIL rdwr_flip2_page: got %b want 1", PAGE); end
        @(negedge CLK); WA = 13'h1234;
        @(negedge CLK); @(negedge CLK);
        n_tests++; if (RD !== 8'hA5) begin n_fail++; $display("FAIL rd_other_page: got %h want a5", RD); end
        WA = 13'h0ABC;
        @(negedge CLK); @(negedge CLK);
        n_tests++; if (RD !== 8'h77) begin n_fail++; $display("FAIL rd_swap_clk_write: got %h want 77", RD); end
    endtask

    task automatic test_reset_mid();
        int fc0;
        pulse_req();
        jump(10'd700, 10'd300);
        after_edges(20);
        n_tests++; if (HS !== 1'b0) begin n_fail++; $display("FAIL mid_hs_active: got %b want 0", HS); end
        @(negedge CLK); RST_N = 1'b0;
        #1;
        n_tests++; if (PAGE !== 1'b0) begin n_fail++; $display("FAIL mid_reset_page: got %b want 0", PAGE); end
        n_tests++; if (HS !== 1'b1) begin n_fail++; $display("FAIL mid_reset_hs: got %b want 1", HS); end
        n_tests++; if (VS !== 1'b1) begin n_fail++; $display("FAIL mid_reset_vs: got %b want 1", VS); end
        @(negedge CLK); RST_N = 1'b1;
        fc0 = flip_cnt;
        jump(10'd799, 10'd479);
        after_edges(4);
        n_tests++; if (PAGE !== 1'b0) begin n_fail++; $display("FAIL mid_after_page: got %b want 0", PAGE); end
        n_tests++; if (flip_cnt != fc0) begin n_fail++; $display("FAIL mid_after_flip: got %0d want %0d", flip_cnt, fc0); end
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_vsync();
        test_flip_pixel();
        test_absorb();
        test_deferred();
        test_rdwr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
